// File: rtl/lib_arbiter_pkg.sv
// Shared arbiter geometry, the packed event word layout and address helpers.
package lib_arbiter_pkg;

  localparam int ROWS      = 32;
  localparam int COLS      = 32;
  localparam int Lvl_ADD   = 2;   // group-level address bits
  localparam int Lvl0_ADD  = 3;   // bits of the sub-address inside a group
  localparam int ROW_ADD   = Lvl_ADD + Lvl0_ADD;
  localparam int COL_ADD   = Lvl_ADD + Lvl0_ADD;
  localparam int SIZE      = 32;  // timestamp width
  localparam int WIDTH     = SIZE + ROW_ADD + COL_ADD + 1;

  // Pixels covered by one group at the bottom level.
  localparam int Lvl0_ROWS = ROWS >> Lvl_ADD;
  localparam int Lvl0_COLS = COLS >> Lvl_ADD;

  localparam int EVT_POL_LSB = 0;
  localparam int EVT_COL_LSB = 1;
  localparam int EVT_ROW_LSB = EVT_COL_LSB + COL_ADD;
  localparam int EVT_TS_LSB  = EVT_ROW_LSB + ROW_ADD;

  // Backward distance above this is read as a wrap of the timestamp counter.
  localparam logic [SIZE-1:0] TS_HALF = {1'b1, {(SIZE-1){1'b0}}};

  typedef struct packed {
    logic [SIZE-1:0]    ts;
    logic [ROW_ADD-1:0] row;
    logic [COL_ADD-1:0] col;
    logic               pol;
  } event_t;

  // {grp, sub} -> grp * group size + sub; kept general for non-power-of-2 groups.
  function automatic logic [ROW_ADD-1:0] abs_row(input logic [ROW_ADD-1:0] f);
    return ROW_ADD'(32'(f[ROW_ADD-1 -: Lvl_ADD]) * 32'(Lvl0_ROWS) + 32'(f[Lvl0_ADD-1:0]));
  endfunction

  function automatic logic [COL_ADD-1:0] abs_col(input logic [COL_ADD-1:0] f);
    return COL_ADD'(32'(f[COL_ADD-1 -: Lvl_ADD]) * 32'(Lvl0_COLS) + 32'(f[Lvl0_ADD-1:0]));
  endfunction

endpackage

// File: rtl/evt_sync_fifo.sv
// Single-clock FIFO with occupancy count and a synchronous flush.
module evt_sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               wdata_i,
  output logic [W-1:0]               rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rptr_q];

  // Flush wins over any same-cycle push or pop.
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage array, no reset needed: contents are only read when counted valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/event_packet_decoder.sv
// Arbiter event receiver: buffer, unpack to absolute pixel address, check ts order, count.
module event_packet_decoder import lib_arbiter_pkg::*; #(
  parameter int FIFO_DEPTH = 8,
  parameter int EVT_CNT_W  = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 clear_i,
  input  logic                 event_valid_i,
  input  logic [WIDTH-1:0]     event_data_i,
  output logic                 event_ready_o,
  output logic                 pix_valid_o,
  input  logic                 pix_ready_i,
  output logic [ROW_ADD-1:0]   pix_row_o,
  output logic [COL_ADD-1:0]   pix_col_o,
  output logic                 pix_pol_o,
  output logic [SIZE-1:0]      pix_ts_o,
  output logic                 ts_err_o,
  output logic                 ts_wrap_o,
  output logic [EVT_CNT_W-1:0] event_count_o
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic             rdy_q;
  logic             vld_q, vld_d;
  event_t           pix_q, pix_d;
  logic [SIZE-1:0]  last_q, last_d;
  logic             have_q, have_d;
  logic             err_q, err_d;
  logic             wrap_q, wrap_d;
  logic [EVT_CNT_W-1:0] cnt_q, cnt_d;

  logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [WIDTH-1:0] fifo_rdata, src;
  logic [CW-1:0]    fifo_cnt;
  logic             push, hs, can_load, load, bypass;
  event_t           raw, dec;
  logic [SIZE-1:0]  ts_back;
  logic             ts_older;

  evt_sync_fifo #(.W(WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (reset_i),
    .flush_i (clear_i),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (event_data_i),
    .rdata_o (fifo_rdata),
    .count_o (fifo_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Ready comes only from the registered FIFO occupancy, never from pix_ready_i.
  assign event_ready_o = rdy_q && !fifo_full;
  assign push          = event_valid_i && event_ready_o;
  assign hs            = vld_q && pix_ready_i;
  assign can_load      = !vld_q || pix_ready_i;
  // An empty FIFO lets the incoming word go straight to the output register.
  assign bypass        = (fifo_cnt == '0);
  assign src           = bypass ? event_data_i : fifo_rdata;
  assign load          = can_load && (!fifo_empty || push);
  assign fifo_pop      = can_load && !fifo_empty;
  assign fifo_push     = push && !(bypass && can_load);

  assign ts_older = (pix_q.ts < last_q);
  assign ts_back  = last_q - pix_q.ts;

  // Unpack the head word into absolute coordinates.
  always_comb begin
    raw     = src;
    dec     = raw;
    dec.row = abs_row(raw.row);
    dec.col = abs_col(raw.col);
  end

  // Output register, timestamp checker and counter next-state; clear overrides all.
  always_comb begin
    vld_d  = vld_q;
    pix_d  = pix_q;
    last_d = last_q;
    have_d = have_q;
    err_d  = err_q;
    wrap_d = 1'b0;
    cnt_d  = cnt_q;
    if (hs) begin
      vld_d  = 1'b0;
      have_d = 1'b1;
      last_d = pix_q.ts;
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      if (have_q && ts_older) begin
        if (ts_back > TS_HALF) wrap_d = 1'b1;
        else                   err_d  = 1'b1;
      end
    end
    if (load) begin
      vld_d = 1'b1;
      pix_d = dec;
    end
    if (clear_i) begin
      vld_d  = 1'b0;
      pix_d  = '0;
      last_d = '0;
      have_d = 1'b0;
      err_d  = 1'b0;
      cnt_d  = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rdy_q  <= 1'b0;
      vld_q  <= 1'b0;
      pix_q  <= '0;
      last_q <= '0;
      have_q <= 1'b0;
      err_q  <= 1'b0;
      wrap_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      rdy_q  <= 1'b1;
      vld_q  <= vld_d;
      pix_q  <= pix_d;
      last_q <= last_d;
      have_q <= have_d;
      err_q  <= err_d;
      wrap_q <= wrap_d;
      cnt_q  <= cnt_d;
    end
  end

  assign pix_valid_o   = vld_q;
  assign pix_row_o     = pix_q.row;
  assign pix_col_o     = pix_q.col;
  assign pix_pol_o     = pix_q.pol;
  assign pix_ts_o      = pix_q.ts;
  assign ts_err_o      = err_q;
  assign ts_wrap_o     = wrap_q;
  assign event_count_o = cnt_q;

endmodule

// File: tb/tb_event_packet_decoder.sv
// Directed + randomized bench for event_packet_decoder with a queue-based reference model.
module tb_event_packet_decoder;
  import lib_arbiter_pkg::*;

  typedef struct {
    logic [31:0] ts;
    logic [1:0]  rg;
    logic [2:0]  rs;
    logic [1:0]  cg;
    logic [2:0]  cs;
    logic        pol;
  } exp_t;

  logic clk = 1'b0;
  logic reset_i = 1'b1, clear_i = 1'b0, event_valid_i = 1'b0, pix_ready_i = 1'b0;
  logic [WIDTH-1:0] event_data_i = '0;
  logic event_ready_o, pix_valid_o, pix_pol_o, ts_err_o, ts_wrap_o;
  logic [ROW_ADD-1:0] pix_row_o;
  logic [COL_ADD-1:0] pix_col_o;
  logic [SIZE-1:0] pix_ts_o;
  logic [15:0] event_count_o;
  logic s_ready, s_valid, s_pol, s_err, s_wrap;
  logic [ROW_ADD-1:0] s_row;
  logic [COL_ADD-1:0] s_col;
  logic [SIZE-1:0] s_ts;
  logic [2:0] s_count;

  always #5 clk = ~clk;

  event_packet_decoder dut (
    .clk_i(clk), .reset_i(reset_i), .clear_i(clear_i),
    .event_valid_i(event_valid_i), .event_data_i(event_data_i), .event_ready_o(event_ready_o),
    .pix_valid_o(pix_valid_o), .pix_ready_i(pix_ready_i),
    .pix_row_o(pix_row_o), .pix_col_o(pix_col_o), .pix_pol_o(pix_pol_o), .pix_ts_o(pix_ts_o),
    .ts_err_o(ts_err_o), .ts_wrap_o(ts_wrap_o), .event_count_o(event_count_o));

  // Narrow-counter copy on the same stimulus, used to reach saturation quickly.
  event_packet_decoder #(.EVT_CNT_W(3)) u_sat (
    .clk_i(clk), .reset_i(reset_i), .clear_i(clear_i),
    .event_valid_i(event_valid_i), .event_data_i(event_data_i), .event_ready_o(s_ready),
    .pix_valid_o(s_valid), .pix_ready_i(pix_ready_i),
    .pix_row_o(s_row), .pix_col_o(s_col), .pix_pol_o(s_pol), .pix_ts_o(s_ts),
    .ts_err_o(s_err), .ts_wrap_o(s_wrap), .event_count_o(s_count));

  int ncmp = 0, nfail = 0;
  exp_t q[$];
  exp_t cur;
  bit m_err = 0, m_wrap = 0, m_have = 0;
  logic [31:0] m_last = '0;
  int m_cnt = 0;
  logic [31:0] gen_ts = 32'h100;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic bound_fail(input string tag);
    ncmp++;
    nfail++;
    $error("FAIL %s: wait bound expired", tag);
  endtask

  function automatic logic [WIDTH-1:0] mkw(input exp_t e);
    return {e.ts, e.rg, e.rs, e.cg, e.cs, e.pol};
  endfunction

  function automatic exp_t rnd_evt();
    exp_t e;
    int r;
    r = $urandom_range(0, 15);
    if (r == 0)      e.ts = gen_ts - $urandom_range(1, 100);
    else if (r == 1) e.ts = $urandom;
    else             e.ts = gen_ts + $urandom_range(0, 10);
    gen_ts = e.ts;
    e.rg = 2'($urandom); e.rs = 3'($urandom);
    e.cg = 2'($urandom); e.cs = 3'($urandom);
    e.pol = 1'($urandom);
    return e;
  endfunction

  function automatic exp_t evt(input logic [31:0] ts);
    exp_t e;
    e = rnd_evt();
    e.ts = ts;
    return e;
  endfunction

  task automatic set_word(input exp_t e);
    cur = e;
    event_data_i = mkw(e);
  endtask

  // Compare every observable output against the model after a clock edge.
  task automatic check_all();
    int sat;
    chk("ready", event_ready_o, q.size() < 9);
    chk("valid", pix_valid_o, q.size() > 0);
    if (q.size() > 0) begin
      chk("row", pix_row_o, int'(q[0].rg) * Lvl0_ROWS + int'(q[0].rs));
      chk("col", pix_col_o, int'(q[0].cg) * Lvl0_COLS + int'(q[0].cs));
      chk("pol", pix_pol_o, q[0].pol);
      chk("ts", pix_ts_o, q[0].ts);
    end
    chk("ts_err", ts_err_o, m_err);
    chk("ts_wrap", ts_wrap_o, m_wrap);
    chk("count", event_count_o, m_cnt);
    sat = (m_cnt > 7) ? 7 : m_cnt;
    chk("sat_count", s_count, sat);
  endtask

  // One clock: update the model from the inputs about to be sampled, clock, check.
  task automatic cyc(output bit acc);
    bit p, h, wr;
    exp_t e;
    longint d;
    wr = 0;
    p = event_valid_i && (q.size() < 9);
    h = (q.size() > 0) && pix_ready_i;
    acc = 0;
    if (clear_i) begin
      q.delete(); m_err = 0; m_cnt = 0; m_have = 0;
    end else begin
      if (h) begin
        e = q.pop_front();
        m_cnt++;
        if (m_have && e.ts < m_last) begin
          d = longint'(m_last) - longint'(e.ts);
          if (d > 64'h8000_0000) wr = 1;
          else m_err = 1;
        end
        m_have = 1;
        m_last = e.ts;
      end
      if (p) begin q.push_back(cur); acc = 1; end
    end
    m_wrap = wr;
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic tick();
    bit a;
    cyc(a);
  endtask

  task automatic send(input exp_t e);
    bit a;
    int n;
    set_word(e);
    event_valid_i = 1;
    n = 0;
    do begin cyc(a); n++; end while (!a && n < 40);
    if (!a) bound_fail("send");
    event_valid_i = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 40) begin tick(); n++; end
    if (q.size() > 0) bound_fail("drain");
    tick();
  endtask

  task automatic do_clear();
    clear_i = 1; tick(); clear_i = 0;
  endtask

  task automatic do_reset();
    reset_i = 1;
    #1;
    chk("rst_ready", event_ready_o, 0);
    chk("rst_valid", pix_valid_o, 0);
    chk("rst_row", pix_row_o, 0);
    chk("rst_col", pix_col_o, 0);
    chk("rst_pol", pix_pol_o, 0);
    chk("rst_ts", pix_ts_o, 0);
    chk("rst_err", ts_err_o, 0);
    chk("rst_wrap", ts_wrap_o, 0);
    chk("rst_count", event_count_o, 0);
    q.delete(); m_err = 0; m_wrap = 0; m_have = 0; m_cnt = 0;
    event_valid_i = 0; clear_i = 0;
    @(posedge clk); @(posedge clk); #1;
    reset_i = 0;
    tick();
  endtask

  initial begin
    bit a;
    int nw;
    exp_t e;
    // Power-on reset
    #2;
    do_reset();

    // T1: single word, bypass latency and address reconstruction
    pix_ready_i = 0;
    e.ts = 32'h10; e.rg = 2'b01; e.rs = 3'b110; e.cg = 2'b10; e.cs = 3'b011; e.pol = 1;
    set_word(e); event_valid_i = 1;
    cyc(a); event_valid_i = 0;
    chk("t1_valid", pix_valid_o, 1);
    chk("t1_row", pix_row_o, 14);
    chk("t1_col", pix_col_o, 19);
    chk("t1_pol", pix_pol_o, 1);
    chk("t1_ts", pix_ts_o, 32'h10);
    pix_ready_i = 1; tick(); pix_ready_i = 0;
    chk("t1_count", event_count_o, 1);

    // T2: stall output, fill buffer, then drain in order
    do_clear();
    for (int i = 0; i < 9; i++) send(evt(32'h20 + i));
    chk("t2_full", event_ready_o, 0);
    set_word(evt(32'h40)); event_valid_i = 1;
    for (int i = 0; i < 3; i++) tick();
    event_valid_i = 0;
    chk("t2_hold_ts", pix_ts_o, 32'h20);
    pix_ready_i = 1;
    drain();
    chk("t2_count", event_count_o, 9);

    // T3: backward timestamp sets a sticky error, event still delivered
    send(evt(100)); send(evt(50)); drain();
    chk("t3_err", ts_err_o, 1);
    chk("t3_count", event_count_o, 11);
    tick(); tick();
    chk("t3_sticky", ts_err_o, 1);

    // T4: wrap pulses once without error
    do_clear();
    send(evt(32'hFFFF_FFF0));
    set_word(evt(32'h5)); event_valid_i = 1;
    nw = 0;
    for (int i = 0; i < 6; i++) begin
      cyc(a);
      if (a) event_valid_i = 0;
      if (ts_wrap_o) nw++;
    end
    chk("t4_wrap_pulses", nw, 1);
    chk("t4_err", ts_err_o, 0);

    // T5: clear with words buffered; next ts check skipped
    send(evt(1000)); drain();
    pix_ready_i = 0;
    for (int i = 0; i < 4; i++) send(evt(2000 + i));
    do_clear();
    chk("t5_valid", pix_valid_o, 0);
    chk("t5_count", event_count_o, 0);
    chk("t5_err", ts_err_o, 0);
    pix_ready_i = 1;
    send(evt(3)); drain();
    chk("t5_first_skip", ts_err_o, 0);

    // Randomized traffic with occasional clears
    for (int i = 0; i < 400; i++) begin
      if (!event_valid_i && $urandom_range(0, 2) != 0) begin
        set_word(rnd_evt()); event_valid_i = 1;
      end
      pix_ready_i = ($urandom_range(0, 3) != 0);
      clear_i = ($urandom_range(0, 63) == 0);
      cyc(a);
      clear_i = 0;
      if (a) event_valid_i = 0;
    end
    event_valid_i = 0; pix_ready_i = 1;
    drain();

    // T6: saturation of the narrow counter, then async reset mid-stream
    do_clear();
    for (int i = 0; i < 9; i++) send(evt(32'h500 + i));
    drain();
    chk("t6_sat", s_count, 7);
    chk("t6_count", event_count_o, 9);
    pix_ready_i = 0;
    for (int i = 0; i < 3; i++) send(evt(32'h600 + i));
    #2;
    do_reset();
    chk("t6_after_valid", pix_valid_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
